seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver. Scans NUM_DIGITS hex digits onto shared cathode lines, one digit at a time. Adds features a single-digit decoder lacks:
- tear-free frame-synchronous value loading
- per-digit decimal points
- leading-zero blanking
- 16-level PWM brightness

It sits between the control/status logic (BPM, patch number, debug values) and the board's display pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  seg7_pkg : shared seven-segment glyph table and polarity helper
//  Revision : 1.0
// ============================================================================
package seg7_pkg;

    // Active-high segment pattern for an unlit digit.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high glyphs, bit0 = a ... bit6 = g: 0-9, A, b, C, d, E, F.
    localparam logic [6:0] GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_active_low(input logic [6:0] seg);
        return ~seg;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  seg7_decode : hex nibble to active-high seven-segment pattern
//  Revision    : 1.0
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPH[nibble];

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  seg7_scan_driver : multiplexed hex display scanner with frame-synchronous
//                     loading, decimal points, zero blanking and PWM dimming
//  Revision         : 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 14
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_in,
    input  logic                    blank_lz_in,
    input  logic [3:0]              bright_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              VAL_W    = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]   slot_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [VAL_W-1:0]      pending_val;
    logic [NUM_DIGITS-1:0] pending_dp;
    logic                  pending_flag;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic                  slot_last;
    logic                  frame_edge;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_lz;
    logic                  blank_now;
    logic                  pwm_on;
    logic [6:0]            glyph_seg;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_last  = &slot_cnt;
    assign frame_edge = slot_last && (digit_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_last) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-buffered value: the display copy only moves on a frame edge,
    // so a frame never mixes old and new digits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_val  <= '0;
            pending_dp   <= '0;
            pending_flag <= 1'b0;
            disp_val     <= '0;
            disp_dp      <= '0;
        end else if (frame_edge) begin
            if (load_in) begin
                disp_val <= val_in;
                disp_dp  <= dp_in;
            end else if (pending_flag) begin
                disp_val <= pending_val;
                disp_dp  <= pending_dp;
            end
            pending_flag <= 1'b0;
        end else if (load_in) begin
            pending_val  <= val_in;
            pending_dp   <= dp_in;
            pending_flag <= 1'b1;
        end
    end

    // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin : p_zero_scan
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (disp_val[i*4 +: 4] == 4'h0);
            zero_from[i] = all_zero;
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        an_next    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nibble = disp_val[i*4 +: 4];
                cur_dp     = disp_dp[i];
                cur_lz     = zero_from[i];
                an_next[i] = ~pwm_on;
            end
        end
    end

    assign blank_now = blank_lz_in && (digit_idx != '0) && cur_lz;

    // Slot cycle 0 is always dark so the cathodes settle before the next anode.
    assign pwm_on = (slot_cnt[DIV_LOG2-1 -: 4] <= bright_in) && (slot_cnt != '0);

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (glyph_seg)
    );

    // ------------------------------------------------------------------
    // Registered pin drivers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cat_out   <= 7'h7F;
            dp_out    <= 1'b1;
            an_out    <= '1;
            frame_out <= 1'b0;
        end else begin
            cat_out   <= seg_active_low(blank_now ? SEG_BLANK : glyph_seg);
            dp_out    <= ~(cur_dp && !blank_now);
            an_out    <= an_next;
            frame_out <= (slot_cnt == '0) && (digit_idx == '0);
        end
    end

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  tb_seg7_scan_driver : directed bench, 4 digits, 16-cycle slots
//  Revision            : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk_in      = 1'b0;
    logic        rst_in      = 1'b1;
    logic [15:0] val_in      = 16'h0000;
    logic [3:0]  dp_in       = 4'h0;
    logic        load_in     = 1'b0;
    logic        blank_lz_in = 1'b0;
    logic [3:0]  bright_in   = 4'hF;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_out;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] bright;
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       frame;
    } vec_t;

    vec_t tbl [16];

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .DIV_LOG2   (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .val_in      (val_in),
        .dp_in       (dp_in),
        .load_in     (load_in),
        .blank_lz_in (blank_lz_in),
        .bright_in   (bright_in),
        .cat_out     (cat_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_out   (frame_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic advance(input int k);
        while (cyc < k) tick();
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] cat,
                             input logic dp, input logic fr);
        cmp({tag, ".an"},    32'(an_out),    32'(an));
        cmp({tag, ".cat"},   32'(cat_out),   32'(cat));
        cmp({tag, ".dp"},    32'(dp_out),    32'(dp));
        cmp({tag, ".frame"}, 32'(frame_out), 32'(fr));
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        val_in  = v;
        dp_in   = d;
        load_in = 1'b1;
        tick();
        load_in = 1'b0;
    endtask

    // Reset lands between clock edges; outputs must blank without a clock.
    task automatic do_reset(input string tag);
        #2 rst_in = 1'b1;
        #1 check_out(tag, 4'hF, 7'h7F, 1'b1, 1'b0);
        load_in = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        cyc = 0;
    endtask

    initial begin
        tbl[0]  = '{1,  4'd15, 4'hF, 7'h40, 1'b1, 1'b1};
        tbl[1]  = '{2,  4'd15, 4'hE, 7'h40, 1'b1, 1'b0};
        tbl[2]  = '{16, 4'd15, 4'hE, 7'h40, 1'b1, 1'b0};
        tbl[3]  = '{17, 4'd15, 4'hF, 7'h40, 1'b1, 1'b0};
        tbl[4]  = '{18, 4'd15, 4'hD, 7'h40, 1'b1, 1'b0};
        tbl[5]  = '{34, 4'd15, 4'hB, 7'h40, 1'b1, 1'b0};
        tbl[6]  = '{50, 4'd15, 4'h7, 7'h40, 1'b1, 1'b0};
        tbl[7]  = '{64, 4'd15, 4'h7, 7'h40, 1'b1, 1'b0};
        tbl[8]  = '{65, 4'd15, 4'hF, 7'h40, 1'b1, 1'b1};
        tbl[9]  = '{66, 4'd15, 4'hE, 7'h40, 1'b1, 1'b0};
        tbl[10] = '{72, 4'd7,  4'hE, 7'h40, 1'b1, 1'b0};
        tbl[11] = '{73, 4'd7,  4'hF, 7'h40, 1'b1, 1'b0};
        tbl[12] = '{88, 4'd7,  4'hD, 7'h40, 1'b1, 1'b0};
        tbl[13] = '{89, 4'd7,  4'hF, 7'h40, 1'b1, 1'b0};
        tbl[14] = '{97, 4'd0,  4'hF, 7'h40, 1'b1, 1'b0};
        tbl[15] = '{98, 4'd0,  4'hF, 7'h40, 1'b1, 1'b0};

        #12 check_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        cyc = 0;

        // Scan order, ghost gap, frame pulse and PWM window
        for (int i = 0; i < 16; i++) begin
            bright_in = tbl[i].bright;
            advance(tbl[i].cyc);
            check_out($sformatf("scan%0d", i), tbl[i].an, tbl[i].cat, tbl[i].dp, tbl[i].frame);
        end

        bright_in = 4'hF;
        do_reset("rst_mid1");

        // Mid-frame load is held until the frame edge at cycle 64
        advance(20);
        pulse_load(16'h1A3F, 4'b0100);
        advance(64);  check_out("hold_old",  4'h7, 7'h40, 1'b1, 1'b0);
        advance(65);  check_out("new_frame", 4'hF, 7'h0E, 1'b1, 1'b1);
        advance(66);  check_out("ld_d0",     4'hE, 7'h0E, 1'b1, 1'b0);
        advance(82);  check_out("ld_d1",     4'hD, 7'h30, 1'b1, 1'b0);
        advance(98);  check_out("ld_d2",     4'hB, 7'h08, 1'b0, 1'b0);
        advance(114); check_out("ld_d3",     4'h7, 7'h79, 1'b1, 1'b0);

        // Two loads in one frame: last one wins, neither shows mid-frame
        advance(140); pulse_load(16'h1111, 4'h0);
        advance(150); pulse_load(16'h2222, 4'h0);
        advance(160); check_out("two_mid1", 4'hD, 7'h30, 1'b1, 1'b0);
        advance(178); check_out("two_mid3", 4'h7, 7'h79, 1'b1, 1'b0);
        advance(194); check_out("two_d0",   4'hE, 7'h24, 1'b1, 1'b0);
        advance(242); check_out("two_d3",   4'h7, 7'h24, 1'b1, 1'b0);

        // Load on the boundary cycle bypasses a stale pending value
        advance(200); pulse_load(16'h5555, 4'h0);
        advance(255); pulse_load(16'h0007, 4'h0);
        advance(258); check_out("bnd_d0",  4'hE, 7'h78, 1'b1, 1'b0);
        advance(274); check_out("bnd_d1",  4'hD, 7'h40, 1'b1, 1'b0);
        advance(322); check_out("bnd_nx0", 4'hE, 7'h78, 1'b1, 1'b0);
        advance(338); check_out("bnd_nx1", 4'hD, 7'h40, 1'b1, 1'b0);

        // Leading-zero blanking
        advance(340); blank_lz_in = 1'b1;
        advance(345); pulse_load(16'h0000, 4'h0);
        advance(386); check_out("z_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        advance(402); check_out("z_d1", 4'hD, 7'h7F, 1'b1, 1'b0);
        advance(418); check_out("z_d2", 4'hB, 7'h7F, 1'b1, 1'b0);
        advance(434); check_out("z_d3", 4'h7, 7'h7F, 1'b1, 1'b0);
        advance(440); pulse_load(16'h0070, 4'b1101);
        advance(450); check_out("lz_d0", 4'hE, 7'h40, 1'b0, 1'b0);
        advance(466); check_out("lz_d1", 4'hD, 7'h78, 1'b1, 1'b0);
        advance(482); check_out("lz_d2", 4'hB, 7'h7F, 1'b1, 1'b0);
        advance(498); check_out("lz_d3", 4'h7, 7'h7F, 1'b1, 1'b0);

        // Reset while a digit is lit clears the display back to zeros
        blank_lz_in = 1'b0;
        advance(500);
        do_reset("rst_mid2");
        advance(1);  check_out("rs_frame", 4'hF, 7'h40, 1'b1, 1'b1);
        advance(2);  check_out("rs_d0",    4'hE, 7'h40, 1'b1, 1'b0);
        advance(18); check_out("rs_d1",    4'hD, 7'h40, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
